net_rate_limiter: RTL and testbench

Token-bucket rate limiter on the NIC transmit path, between the NIC's outgoing 64-bit frame stream and the network port (`net_out_*`). It consumes the rate-limiter settings the network endpoint publishes (`rlimit_inc`, `rlimit_period`, `rlimit_size`) and throttles beat acceptance so that long-run throughput equals inc/(period+1) beats per cycle, with bursts of up to `size` beats. Settings are sampled only between frames, so a frame is never split across two rate configurations.

---
 rtl/net_rate_limiter.sv | 164 ++++++++++++++++
 tb/tb_net_rate_limiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/net_rate_limiter.sv
`default_nettype none
// ============================================================================
//  Module      : net_rate_limiter
//  Description : Token-bucket rate limiter on the NIC transmit path. Beats
//                are passed through combinationally and admitted only while
//                the bucket holds a token. Settings are latched between
//                frames, so one frame never sees two rate configurations.
//                Optional statistics counters: define NET_RLIMIT_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module net_rate_limiter (
    input  logic        clock,
    input  logic        reset,          // asynchronous, active-low
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_bits_data,
    input  logic [7:0]  in_bits_keep,
    input  logic        in_bits_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_bits_data,
    output logic [7:0]  out_bits_keep,
    output logic        out_bits_last,
    input  logic [7:0]  rlimit_inc,
    input  logic [7:0]  rlimit_period,
    input  logic [7:0]  rlimit_size,
    output logic [31:0] frame_count,
    output logic [31:0] stall_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0] state_q, state_d;
    logic [7:0] inc_q, inc_d;
    logic [7:0] period_q, period_d;
    logic [7:0] size_q, size_d;
    logic [7:0] tokens_q, tokens_d;
    logic [7:0] pcnt_q, pcnt_d;

    logic       have_token;
    logic       fire;
    logic       stall;
    logic       refill;
    logic       load_settings;
    logic [8:0] tok_sum;

    // Payload is a pure pass-through; only the handshake is gated.
    assign out_bits_data = in_bits_data;
    assign out_bits_keep = in_bits_keep;
    assign out_bits_last = in_bits_last;

    // Handshake qualifiers, derived from registered tokens only.
    always_comb begin
        have_token = (tokens_q != 8'd0);
        fire       = in_valid && out_ready && have_token;
        stall      = in_valid && out_ready && !have_token;
        refill     = (pcnt_q == period_q);
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: BUSY from the first non-last beat until the last beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fire && !in_bits_last) state_d = ST_BUSY;
            ST_BUSY: if (fire && in_bits_last)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake gating and the between-frames settings window.
    always_comb begin
        out_valid     = in_valid && have_token;
        in_ready      = out_ready && have_token;
        load_settings = (state_q == ST_IDLE);
    end

    // Settings track the inputs while idle and freeze for the rest of a frame.
    always_comb begin
        inc_d    = inc_q;
        period_d = period_q;
        size_d   = size_q;
        if (load_settings) begin
            inc_d    = rlimit_inc;
            period_d = rlimit_period;
            size_d   = rlimit_size;
        end
    end

    // Period counter; an out-of-range count after a period shrink restarts
    // at zero without granting a refill.
    always_comb begin
        pcnt_d = pcnt_q + 8'd1;
        if (refill || (pcnt_q > period_q)) begin
            pcnt_d = 8'd0;
        end
    end

    // Bucket update in 9 bits so inc + tokens cannot wrap before the clamp.
    // A fire implies tokens != 0, so the subtraction never underflows.
    always_comb begin
        tok_sum  = {1'b0, tokens_q} - {8'd0, fire}
                 + (refill ? {1'b0, inc_q} : 9'd0);
        tokens_d = (tok_sum > {1'b0, size_q}) ? size_q : tok_sum[7:0];
    end

    // Limiter state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inc_q    <= 8'd0;
            period_q <= 8'd0;
            size_q   <= 8'd0;
            tokens_q <= 8'd0;
            pcnt_q   <= 8'd0;
        end else begin
            inc_q    <= inc_d;
            period_q <= period_d;
            size_q   <= size_d;
            tokens_q <= tokens_d;
            pcnt_q   <= pcnt_d;
        end
    end

`ifdef NET_RLIMIT_STATS_EN
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Statistics next values; both wrap naturally at 2^32.
    always_comb begin
        frame_cnt_d = frame_cnt_q + {31'd0, (fire && in_bits_last)};
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
    end

    // Statistics registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign frame_count = frame_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign frame_count  = 32'd0;
    assign stall_count  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_net_rate_limiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_net_rate_limiter
//  Description : Directed self-checking bench for net_rate_limiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_net_rate_limiter;

`ifdef NET_RLIMIT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_bits_data;
    logic [7:0]  in_bits_keep;
    logic        in_bits_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_bits_data;
    logic [7:0]  out_bits_keep;
    logic        out_bits_last;
    logic [7:0]  rlimit_inc;
    logic [7:0]  rlimit_period;
    logic [7:0]  rlimit_size;
    logic [31:0] frame_count;
    logic [31:0] stall_count;

    int checks = 0;
    int errors = 0;
    int bif = 0;          // beats already accepted in the current frame
    int frame_len = 64;
    int n;
    logic [31:0] s0;

    net_rate_limiter dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_bits_data  (in_bits_data),
        .in_bits_keep  (in_bits_keep),
        .in_bits_last  (in_bits_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_bits_data (out_bits_data),
        .out_bits_keep (out_bits_keep),
        .out_bits_last (out_bits_last),
        .rlimit_inc    (rlimit_inc),
        .rlimit_period (rlimit_period),
        .rlimit_size   (rlimit_size),
        .frame_count   (frame_count),
        .stall_count   (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Present beats for ncyc cycles, counting accepted ones; inputs change
    // 1 ns after each rising edge, handshake is sampled on the falling edge.
    task automatic run(input int ncyc, output int nbeats);
        nbeats = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clock);
            if (in_valid && in_ready) begin
                nbeats++;
                if (in_bits_last) bif = 0;
                else              bif++;
            end
            @(posedge clock);
            #1;
            in_bits_last = (bif == frame_len - 1);
            in_bits_data = {$urandom(), $urandom()};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        in_valid      = 1'b1;
        out_ready     = 1'b1;
        in_bits_data  = 64'h0123_4567_89ab_cdef;
        in_bits_keep  = 8'hff;
        in_bits_last  = 1'b0;
        rlimit_inc    = 8'd1;
        rlimit_period = 8'd1;
        rlimit_size   = 8'd8;

        // ---- reset state ----
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready",  in_ready,    0);
        chk("rst_out_valid", out_valid,   0);
        chk("rst_frames",    frame_count, 0);
        chk("rst_stalls",    stall_count, 0);

        // ---- steady rate: inc=1 period=1 size=8, let bucket fill idle ----
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        in_valid = 1'b1;
        bif = 0; frame_len = 64; in_bits_last = 1'b0;
        run(1, n);   chk("steady_first_beat", n, 1);
        // mid-frame settings change must not affect this frame
        rlimit_inc = 8'd1; rlimit_period = 8'd7;
        run(15, n);  chk("steady_burst", n, 15);
        run(1, n);   chk("steady_empty", n, 0);
        run(20, n);  chk("steady_half_rate", n, 10);
        run(75, n);  chk("steady_tail", n, 38);
        chk("frame1_count", frame_count, STATS ? 1 : 0);
        frame_len = 1000;

        // ---- next frame runs at the new rate: 1 beat per 8 cycles ----
        run(1, n);   chk("f2_gap", n, 0);
        run(1, n);   chk("f2_first", n, 1);
        run(32, n);  chk("f2_rate", n, 4);
        chk("stall_total", stall_count, STATS ? 77 : 0);

        // ---- asynchronous reset clears statistics immediately ----
        #2;
        reset = 1'b0;
        #1;
        chk("rst2_frames", frame_count, 0);
        chk("rst2_stalls", stall_count, 0);

        // ---- full rate: inc=8 period=0 size=8, frames of 4 beats ----
        @(posedge clock); #1;
        rlimit_inc = 8'd8; rlimit_period = 8'd0; rlimit_size = 8'd8;
        bif = 0; frame_len = 4; in_bits_last = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        reset = 1'b1;
        run(1, n);   chk("full_c0", n, 0);
        run(1, n);   chk("full_c1", n, 0);
        run(20, n);  chk("full_rate", n, 20);
        chk("full_frames", frame_count, STATS ? 5 : 0);
        chk("full_stalls", stall_count, STATS ? 2 : 0);

        // downstream back-pressure: valid stays up, nothing accepted
        out_ready = 1'b0;
        @(negedge clock);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_in_ready",  in_ready,  0);
        chk("bp_data",      out_bits_data, in_bits_data);
        @(posedge clock); #1;
        out_ready = 1'b1;
        run(2, n);   chk("mid_frame_beats", n, 2);
        chk("fire_refill_full", dut.tokens_q, 8);
        chk("stalls_after_bp", stall_count, STATS ? 2 : 0);

        // ---- async reset mid-frame, between edges ----
        #2;
        reset = 1'b0;
        #1;
        chk("arst_in_ready",  in_ready,     0);
        chk("arst_out_valid", out_valid,    0);
        chk("arst_tokens",    dut.tokens_q, 0);
        chk("arst_frames",    frame_count,  0);
        chk("arst_stalls",    stall_count,  0);

        // ---- blocked traffic: size=0 ----
        @(posedge clock); #1;
        rlimit_inc = 8'd1; rlimit_period = 8'd0; rlimit_size = 8'd0;
        bif = 0; frame_len = 4; in_bits_last = 1'b0;
        reset = 1'b1;
        run(3, n);   chk("blk_settle", n, 0);
        s0 = stall_count;
        run(10, n);  chk("blk_beats", n, 0);
        chk("blk_stalls", stall_count - s0, STATS ? 10 : 0);
        chk("blk_frames", frame_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
